pc_redirect_ctrl: RTL and testbench

//  Sequences every PC redirect in the pipeline. Sources are the EXE branch compare (BTYPE_FLUSH/BTYPE_REAL_ADDR), JALR and trap.

---
 rtl/pc_redirect_ctrl_pkg.sv | 17 +
 rtl/pc_redirect_ctrl_if.sv | 33 +++
 rtl/pc_redirect_ctrl_prio_sel.sv | 30 +++
 rtl/pc_redirect_ctrl.sv | 91 +++++++++
 tb/tb_pc_redirect_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the PC redirect controller: FSM states and redirect source ids.
package pc_redirect_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_SHADOW   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_TRAP  = 2'd1,
    SRC_BTYPE = 2'd2,
    SRC_JALR  = 2'd3
  } src_e;
endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Redirect bus between EXE/CSR request sources, the IF PC mux and the pipeline flush lines.
interface pc_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import pc_redirect_pkg::*;

  logic             TRAP_vld;
  logic [XLEN-1:0]  TRAP_ADDR;
  logic             BTYPE_FLUSH;
  logic [XLEN-1:0]  BTYPE_REAL_ADDR;
  logic             JALR_vld;
  logic [XLEN-1:0]  JALR_ADDR;
  // REDIR_vld/IF_ready: a transfer happens on a rising edge where both are high;
  // REDIR_ADDR is stable while REDIR_vld is high unless a trap re-targets it.
  logic             IF_ready;
  logic             REDIR_vld;
  logic [XLEN-1:0]  REDIR_ADDR;
  logic             FLUSH_IFID;
  logic             FLUSH_IDEX;
  logic [CNT_W-1:0] REDIR_cnt;
  state_e           dbg_state;

  modport master (
    input  TRAP_vld, TRAP_ADDR, BTYPE_FLUSH, BTYPE_REAL_ADDR, JALR_vld, JALR_ADDR, IF_ready,
    output REDIR_vld, REDIR_ADDR, FLUSH_IFID, FLUSH_IDEX, REDIR_cnt, dbg_state
  );

  modport slave (
    output TRAP_vld, TRAP_ADDR, BTYPE_FLUSH, BTYPE_REAL_ADDR, JALR_vld, JALR_ADDR, IF_ready,
    input  REDIR_vld, REDIR_ADDR, FLUSH_IFID, FLUSH_IDEX, REDIR_cnt, dbg_state
  );
endinterface

// File: rtl/pc_redirect_ctrl_prio_sel.sv
// Fixed-priority pick among trap, branch and JALR redirect requests (TRAP > BTYPE > JALR).
module redirect_prio_sel #(
  parameter int XLEN = 32
) (
  input  logic                     trap_vld_i,
  input  logic [XLEN-1:0]          trap_addr_i,
  input  logic                     btype_vld_i,
  input  logic [XLEN-1:0]          btype_addr_i,
  input  logic                     jalr_vld_i,
  input  logic [XLEN-1:0]          jalr_addr_i,
  output pc_redirect_pkg::src_e    src_o,
  output logic [XLEN-1:0]          addr_o
);
  import pc_redirect_pkg::*;

  always_comb begin
    src_o  = SRC_NONE;
    addr_o = '0;
    if (trap_vld_i) begin
      src_o  = SRC_TRAP;
      addr_o = trap_addr_i;
    end else if (btype_vld_i) begin
      src_o  = SRC_BTYPE;
      addr_o = btype_addr_i;
    end else if (jalr_vld_i) begin
      src_o  = SRC_JALR;
      addr_o = jalr_addr_i;
    end
  end
endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: latches the winning redirect target, hands it to IF and
// holds IF/ID flushed for a shadow window after IF takes it.
module pc_redirect_ctrl #(
  parameter int XLEN   = 32,
  parameter int SHADOW = 2,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  pc_redirect_ctrl_if.master bus
);
  import pc_redirect_pkg::*;

  localparam int SCNT_W = (SHADOW > 1) ? $clog2(SHADOW) : 1;
  localparam logic [XLEN-1:0] BIT0_MASK = {{(XLEN-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [XLEN-1:0]   addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SCNT_W-1:0] scnt_q;

  src_e              sel_src;
  logic [XLEN-1:0]   sel_addr;
  logic [XLEN-1:0]   lat_addr;
  logic              any_req;

  redirect_prio_sel #(.XLEN(XLEN)) u_prio_sel (
    .trap_vld_i   (bus.TRAP_vld),
    .trap_addr_i  (bus.TRAP_ADDR),
    .btype_vld_i  (bus.BTYPE_FLUSH),
    .btype_addr_i (bus.BTYPE_REAL_ADDR),
    .jalr_vld_i   (bus.JALR_vld),
    .jalr_addr_i  (bus.JALR_ADDR),
    .src_o        (sel_src),
    .addr_o       (sel_addr)
  );

  assign any_req  = (sel_src != SRC_NONE);
  // Targets are at least halfword aligned; bit0 never reaches the PC.
  assign lat_addr = sel_addr & ~BIT0_MASK;

  // Outside IDLE only a trap can win the selector, so lat_addr is the trap target there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            addr_q  <= lat_addr;
            state_q <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (bus.TRAP_vld) begin
            addr_q <= lat_addr;
          end else if (bus.IF_ready) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (SHADOW > 0) begin
              state_q <= S_SHADOW;
              scnt_q  <= SCNT_W'(SHADOW - 1);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_SHADOW: begin
          if (bus.TRAP_vld) begin
            addr_q  <= lat_addr;
            state_q <= S_REDIRECT;
          end else if (scnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            scnt_q <= scnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.REDIR_vld  = (state_q == S_REDIRECT);
  assign bus.REDIR_ADDR = addr_q;
  assign bus.REDIR_cnt  = cnt_q;
  assign bus.dbg_state  = state_q;
  assign bus.FLUSH_IFID = !rst && ((state_q != S_IDLE) || any_req);
  assign bus.FLUSH_IDEX = !rst && ((state_q == S_IDLE) ? any_req : bus.TRAP_vld);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;
  import pc_redirect_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();

  pc_redirect_ctrl #(.XLEN(32), .SHADOW(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic trap, input logic [31:0] ta,
                       input logic btype, input logic [31:0] ba,
                       input logic jalr, input logic [31:0] ja,
                       input logic rdy);
    bus.TRAP_vld        = trap;
    bus.TRAP_ADDR       = ta;
    bus.BTYPE_FLUSH     = btype;
    bus.BTYPE_REAL_ADDR = ba;
    bus.JALR_vld        = jalr;
    bus.JALR_ADDR       = ja;
    bus.IF_ready        = rdy;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic vld, input logic [31:0] addr,
                          input logic ifid, input logic idex);
    chk({tag, "_vld"},  32'(bus.REDIR_vld),  32'(vld));
    chk({tag, "_addr"}, bus.REDIR_ADDR,      addr);
    chk({tag, "_ifid"}, 32'(bus.FLUSH_IFID), 32'(ifid));
    chk({tag, "_idex"}, 32'(bus.FLUSH_IDEX), 32'(idex));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle_inputs();

    // reset state; a request during reset must not raise flushes
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 1'b0);
    settle();
    chk_outs("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_cnt",   32'(bus.REDIR_cnt), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    idle_inputs();
    tick();
    rst = 1'b0;
    settle();
    chk_outs("idle", 1'b0, 32'h0, 1'b0, 1'b0);

    // 1: branch redirect, accepted on the first REDIRECT cycle
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
    settle();
    chk_outs("t1_c0", 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    settle();
    chk_outs("t1_c1", 1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk_outs("t1_c2", 1'b0, 32'h100, 1'b1, 1'b0);
    chk("t1_cnt",   32'(bus.REDIR_cnt), 32'd1);
    chk("t1_state", 32'(bus.dbg_state), 32'(S_SHADOW));
    tick();
    settle();
    chk_outs("t1_c3", 1'b0, 32'h100, 1'b1, 1'b0);
    tick();
    settle();
    chk_outs("t1_c4", 1'b0, 32'h100, 1'b0, 1'b0);
    chk("t1_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    // 2: all three sources in one cycle, trap wins
    tick();
    drive(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0);
    settle();
    chk_outs("t2_c0", 1'b0, 32'h100, 1'b1, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk_outs("t2_c1", 1'b1, 32'h80, 1'b1, 1'b0);

    // 3: IF stalls 5 cycles, wrong-path branch pulses ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, (i % 2) == 1, 32'h0000_0400, 1'b0, 32'h0, 1'b0);
      settle();
      chk_outs($sformatf("t3_hold%0d", i), 1'b1, 32'h80, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk("t3_cnt", 32'(bus.REDIR_cnt), 32'd2);
    tick();
    tick();
    settle();
    chk("t3_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    // 4: trap re-targets a pending redirect and beats same-cycle IF_ready
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0080, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    settle();
    chk_outs("t4_c1", 1'b1, 32'h200, 1'b1, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk_outs("t4_c2", 1'b1, 32'h80, 1'b1, 1'b0);
    chk("t4_cnt",   32'(bus.REDIR_cnt), 32'd2);
    chk("t4_state", 32'(bus.dbg_state), 32'(S_REDIRECT));
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    // trap during the shadow window restarts the redirect; branch is not
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0600, 1'b0, 32'h0, 1'b0);
    settle();
    chk_outs("t4_shadow_br", 1'b0, 32'h80, 1'b1, 1'b0);
    chk("t4_cnt2", 32'(bus.REDIR_cnt), 32'd3);
    tick();
    drive(1'b1, 32'h0000_00A1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    settle();
    chk_outs("t4_shadow_trap", 1'b0, 32'h80, 1'b1, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk_outs("t4_retrap", 1'b1, 32'hA0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    idle_inputs();
    tick();
    tick();
    settle();
    chk("t4_cnt3", 32'(bus.REDIR_cnt), 32'd4);
    chk("t4_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    // 5: JALR target bit0 cleared
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0105, 1'b0);
    settle();
    chk_outs("t5_c0", 1'b0, 32'hA0, 1'b1, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk_outs("t5_c1", 1'b1, 32'h104, 1'b1, 1'b0);

    // 6: reset mid-REDIRECT with the request still held
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    settle();
    chk_outs("t6_rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_rst_cnt", 32'(bus.REDIR_cnt), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    settle();
    chk_outs("t6_after", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_state", 32'(bus.dbg_state), 32'(S_IDLE));
    tick();
    settle();
    chk("t6_no_replay", 32'(bus.REDIR_vld), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
